// File: rtl/calc_moments_n.sv
// Raw image moments (m00, m01, m10) of a binary frame streamed PIX pixels per word,
// with a registered adder tree, saturating accumulators and a rd_done-timed output strobe.
module calc_moments_n #(
    parameter int unsigned PIX    = 8,
    parameter int unsigned VCNT_W = 11,
    parameter int unsigned HCNT_W = 11,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cnt_en,
    input  logic              din_valid,
    input  logic [VCNT_W-1:0] vcount,
    input  logic [HCNT_W-1:0] hcount,
    input  logic [PIX-1:0]    idata,
    input  logic              rd_done,
    output logic [ACC_W-1:0]  m00,
    output logic [ACC_W-1:0]  m01,
    output logic [ACC_W-1:0]  m10,
    output logic              m_done,
    output logic              ovf
);
    localparam int unsigned T  = $clog2(PIX);
    localparam int unsigned CW = T + 1;
    localparam int unsigned VW = VCNT_W + T;
    localparam int unsigned HW = HCNT_W + 1 + T;
    localparam int unsigned TW = (HW > VW) ? HW : VW;
    localparam int unsigned SW = ((ACC_W > TW) ? ACC_W : TW) + 1;

    logic              s0_valid;
    logic [VCNT_W-1:0] s0_v;
    logic [HCNT_W-1:0] s0_h;
    logic [PIX-1:0]    s0_d;
    logic [PIX-1:0]    px;

    // Level 0 holds the per-pixel terms; level l holds the l-th adder-tree stage.
    logic [CW-1:0] c_t [0:T][0:PIX-1];
    logic [VW-1:0] v_t [0:T][0:PIX-1];
    logic [HW-1:0] h_t [0:T][0:PIX-1];

    logic [ACC_W-1:0] acc00, acc01, acc10;
    logic [ACC_W:0]   r00, r01, r10;
    logic [T+2:0]     rd_sr;

    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SW-1:0]    b);
        logic [SW-1:0] s;
        s = SW'(a) + b;
        if (|s[SW-1:ACC_W])
            return {1'b1, {ACC_W{1'b1}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s0_valid <= 1'b0;
            s0_v     <= '0;
            s0_h     <= '0;
            s0_d     <= '0;
        end else begin
            s0_valid <= din_valid & ~cnt_en;
            s0_v     <= cnt_en ? '0 : vcount;
            s0_h     <= cnt_en ? '0 : hcount;
            s0_d     <= cnt_en ? '0 : idata;
        end
    end

    // Bubbles are zeroed here, so the tree and accumulators need no valid qualifier.
    always_comb begin
        px = '0;
        for (int unsigned k = 0; k < PIX; k++)
            px[k] = s0_valid & s0_d[PIX-1-k];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned l = 0; l <= T; l++)
                for (int unsigned i = 0; i < PIX; i++) begin
                    c_t[l][i] <= '0;
                    v_t[l][i] <= '0;
                    h_t[l][i] <= '0;
                end
        end else begin
            for (int unsigned k = 0; k < PIX; k++) begin
                c_t[0][k] <= (px[k] && !cnt_en) ? CW'(1) : '0;
                v_t[0][k] <= (px[k] && !cnt_en) ? VW'(s0_v) : '0;
                h_t[0][k] <= (px[k] && !cnt_en) ?
                             HW'({1'b0, s0_h} + (HCNT_W+1)'(k)) : '0;
            end
            for (int unsigned l = 1; l <= T; l++) begin
                for (int unsigned i = 0; i < PIX/2; i++) begin
                    c_t[l][i] <= cnt_en ? '0 : c_t[l-1][2*i] + c_t[l-1][2*i+1];
                    v_t[l][i] <= cnt_en ? '0 : v_t[l-1][2*i] + v_t[l-1][2*i+1];
                    h_t[l][i] <= cnt_en ? '0 : h_t[l-1][2*i] + h_t[l-1][2*i+1];
                end
                for (int unsigned i = PIX/2; i < PIX; i++) begin
                    c_t[l][i] <= '0;
                    v_t[l][i] <= '0;
                    h_t[l][i] <= '0;
                end
            end
        end
    end

    always_comb begin
        r00 = sat_add(acc00, SW'(c_t[T][0]));
        r01 = sat_add(acc01, SW'(v_t[T][0]));
        r10 = sat_add(acc10, SW'(h_t[T][0]));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc00 <= '0;
            acc01 <= '0;
            acc10 <= '0;
            ovf   <= 1'b0;
        end else if (cnt_en) begin
            acc00 <= '0;
            acc01 <= '0;
            acc10 <= '0;
            ovf   <= 1'b0;
        end else begin
            acc00 <= r00[ACC_W-1:0];
            acc01 <= r01[ACC_W-1:0];
            acc10 <= r10[ACC_W-1:0];
            ovf   <= ovf | r00[ACC_W] | r01[ACC_W] | r10[ACC_W];
        end
    end

    // rd_sr plus the output register form the T+4 deep rd_done delay line.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_sr  <= '0;
            m_done <= 1'b0;
            m00    <= '0;
            m01    <= '0;
            m10    <= '0;
        end else if (cnt_en) begin
            rd_sr  <= '0;
            m_done <= 1'b0;
            m00    <= '0;
            m01    <= '0;
            m10    <= '0;
        end else begin
            rd_sr  <= {rd_sr[T+1:0], rd_done};
            m_done <= rd_sr[T+2];
            if (rd_sr[T+2]) begin
                m00 <= acc00;
                m01 <= acc01;
                m10 <= acc10;
            end
        end
    end
endmodule

// File: tb/tb_calc_moments_n.sv
// Directed-vector bench for calc_moments_n: PIX=8 (32- and 8-bit accumulators) and PIX=32.
module tb_calc_moments_n;
    logic        clk = 1'b0;
    logic        nrst, cnt_en, rd_done;
    logic        din_valid, din_valid32;
    logic [10:0] vcount, hcount, vcount32, hcount32;
    logic [7:0]  idata;
    logic [31:0] idata32;

    logic [31:0] m00_a, m01_a, m10_a, m00_w, m01_w, m10_w;
    logic [7:0]  m00_s, m01_s, m10_s;
    logic        done_a, ovf_a, done_s, ovf_s, done_w, ovf_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    calc_moments_n #(.PIX(8), .VCNT_W(11), .HCNT_W(11), .ACC_W(32)) u_a (
        .clk(clk), .nrst(nrst), .cnt_en(cnt_en), .din_valid(din_valid),
        .vcount(vcount), .hcount(hcount), .idata(idata), .rd_done(rd_done),
        .m00(m00_a), .m01(m01_a), .m10(m10_a), .m_done(done_a), .ovf(ovf_a));

    calc_moments_n #(.PIX(8), .VCNT_W(11), .HCNT_W(11), .ACC_W(8)) u_s (
        .clk(clk), .nrst(nrst), .cnt_en(cnt_en), .din_valid(din_valid),
        .vcount(vcount), .hcount(hcount), .idata(idata), .rd_done(rd_done),
        .m00(m00_s), .m01(m01_s), .m10(m10_s), .m_done(done_s), .ovf(ovf_s));

    calc_moments_n #(.PIX(32), .VCNT_W(11), .HCNT_W(11), .ACC_W(32)) u_w (
        .clk(clk), .nrst(nrst), .cnt_en(cnt_en), .din_valid(din_valid32),
        .vcount(vcount32), .hcount(hcount32), .idata(idata32), .rd_done(rd_done),
        .m00(m00_w), .m01(m01_w), .m10(m10_w), .m_done(done_w), .ovf(ovf_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        cnt_en = 1'b0; rd_done = 1'b0;
        din_valid = 1'b0; idata = '0; vcount = '0; hcount = '0;
        din_valid32 = 1'b0; idata32 = '0; vcount32 = '0; hcount32 = '0;
    endtask

    task automatic frame_clear();
        clr_in();
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
    endtask

    task automatic test_reset();
        clr_in();
        nrst = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if ({m00_a, m01_a, m10_a, done_a, ovf_a} !== '0) begin
                n_bad++;
                $display("FAIL reset_a cyc%0d: got m00=%0d m01=%0d m10=%0d done=%b ovf=%b want all 0",
                         i, m00_a, m01_a, m10_a, done_a, ovf_a);
            end
            n_cmp++;
            if ({m00_w, m01_w, m10_w, done_w, ovf_w, m00_s, done_s, ovf_s} !== '0) begin
                n_bad++;
                $display("FAIL reset_w cyc%0d: got m00w=%0d done_w=%b ovf_w=%b m00s=%0d want all 0",
                         i, m00_w, done_w, ovf_w, m00_s);
            end
        end
    endtask

    task automatic test_single_word();
        frame_clear();
        idata = 8'hFF; vcount = 11'd5; hcount = 11'd16; din_valid = 1'b1; rd_done = 1'b1;
        tick();
        clr_in();
        repeat (5) tick();
        n_cmp++;
        if (done_a !== 1'b0) begin
            n_bad++; $display("FAIL single_early_done: got %b want 0", done_a);
        end
        tick();
        n_cmp++;
        if (done_a !== 1'b1) begin
            n_bad++; $display("FAIL single_done: got %b want 1", done_a);
        end
        n_cmp++;
        if (m00_a !== 32'd8 || m01_a !== 32'd40 || m10_a !== 32'd156) begin
            n_bad++;
            $display("FAIL single_moments: got %0d/%0d/%0d want 8/40/156", m00_a, m01_a, m10_a);
        end
        tick();
        n_cmp++;
        if (done_a !== 1'b0 || m00_a !== 32'd8) begin
            n_bad++;
            $display("FAIL single_hold: got done=%b m00=%0d want done=0 m00=8", done_a, m00_a);
        end
    endtask

    task automatic test_valid_qualifier();
        frame_clear();
        idata = 8'hFF; vcount = 11'd5; hcount = 11'd9; din_valid = 1'b0;
        tick();
        idata = 8'h81; vcount = 11'd3; hcount = 11'd0; din_valid = 1'b1;
        tick();
        clr_in();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (done_a !== 1'b1 || m00_a !== 32'd2 || m01_a !== 32'd6 || m10_a !== 32'd7) begin
            n_bad++;
            $display("FAIL valid_qual: got done=%b %0d/%0d/%0d want done=1 2/6/7",
                     done_a, m00_a, m01_a, m10_a);
        end
    endtask

    task automatic test_saturation();
        frame_clear();
        for (int i = 0; i < 40; i++) begin
            idata = 8'hFF; vcount = 11'd1; hcount = 11'd0; din_valid = 1'b1;
            rd_done = (i == 39);
            tick();
        end
        clr_in();
        repeat (6) tick();
        n_cmp++;
        if (done_s !== 1'b1 || m00_s !== 8'd255 || m01_s !== 8'd255 || m10_s !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_values: got done=%b %0d/%0d/%0d want done=1 255/255/255",
                     done_s, m00_s, m01_s, m10_s);
        end
        n_cmp++;
        if (ovf_s !== 1'b1) begin
            n_bad++; $display("FAIL sat_ovf: got %b want 1", ovf_s);
        end
        n_cmp++;
        if (m00_a !== 32'd320 || m01_a !== 32'd320 || m10_a !== 32'd1120 || ovf_a !== 1'b0) begin
            n_bad++;
            $display("FAIL wide_no_sat: got %0d/%0d/%0d ovf=%b want 320/320/1120 ovf=0",
                     m00_a, m01_a, m10_a, ovf_a);
        end
        cnt_en = 1'b1;
        tick();
        cnt_en = 1'b0;
        n_cmp++;
        if ({m00_s, m01_s, m10_s, ovf_s, done_s} !== '0) begin
            n_bad++;
            $display("FAIL sat_clear: got %0d/%0d/%0d ovf=%b done=%b want all 0",
                     m00_s, m01_s, m10_s, ovf_s, done_s);
        end
    endtask

    task automatic test_clear_priority();
        frame_clear();
        idata = 8'hFF; vcount = 11'd2; hcount = 11'd4; din_valid = 1'b1;
        tick();
        clr_in();
        tick();
        idata = 8'hFF; vcount = 11'd2; hcount = 11'd4; din_valid = 1'b1; cnt_en = 1'b1;
        tick();
        clr_in();
        repeat (3) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (done_a !== 1'b1 || m00_a !== 32'd0 || m10_a !== 32'd0) begin
            n_bad++;
            $display("FAIL clear_prio: got done=%b m00=%0d m10=%0d want done=1 0/0",
                     done_a, m00_a, m10_a);
        end
        rd_done = 1'b1; cnt_en = 1'b1;
        tick();
        clr_in();
        begin
            int seen = 0;
            repeat (10) begin
                tick();
                if (done_a === 1'b1) seen++;
            end
            n_cmp++;
            if (seen !== 0) begin
                n_bad++; $display("FAIL clear_drops_rd: got %0d strobes want 0", seen);
            end
        end
    endtask

    task automatic test_reset_abort();
        frame_clear();
        idata = 8'hF0; vcount = 11'd7; hcount = 11'd3; din_valid = 1'b1; rd_done = 1'b1;
        tick();
        clr_in();
        tick();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        begin
            int seen = 0;
            repeat (10) begin
                tick();
                if (done_a === 1'b1) seen++;
            end
            n_cmp++;
            if (seen !== 0 || m00_a !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_abort: got strobes=%0d m00=%0d want 0/0", seen, m00_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        longint a00 = 0, a01 = 0, a10 = 0, w00 = 0, w01 = 0, w10 = 0;
        longint sa00 [2], sa01 [2], sa10 [2], sw00 [2], sw01 [2], sw10 [2];
        int strobes_a = 0, strobes_w = 0;
        frame_clear();
        for (int n = 0; n < 1000; n++) begin
            din_valid   = ($urandom_range(0, 3) != 0);
            idata       = 8'($urandom);
            vcount      = 11'($urandom_range(0, 2047));
            hcount      = 11'($urandom_range(0, 2047));
            din_valid32 = ($urandom_range(0, 3) != 0);
            idata32     = $urandom;
            vcount32    = 11'($urandom_range(0, 2047));
            hcount32    = 11'($urandom_range(0, 2047));
            rd_done     = (n == 995) || (n == 998);
            if (din_valid)
                for (int k = 0; k < 8; k++)
                    if (idata[7-k]) begin
                        a00 += 1; a01 += longint'(vcount); a10 += longint'(hcount) + k;
                    end
            if (din_valid32)
                for (int k = 0; k < 32; k++)
                    if (idata32[31-k]) begin
                        w00 += 1; w01 += longint'(vcount32); w10 += longint'(hcount32) + k;
                    end
            if (rd_done) begin
                int s = (n == 995) ? 0 : 1;
                sa00[s] = a00; sa01[s] = a01; sa10[s] = a10;
                sw00[s] = w00; sw01[s] = w01; sw10[s] = w10;
            end
            tick();
        end
        clr_in();
        for (int c = 1000; c <= 1010; c++) begin
            if (done_a === 1'b1) strobes_a++;
            if (done_w === 1'b1) strobes_w++;
            if (c == 1002 || c == 1005) begin
                int s = (c == 1002) ? 0 : 1;
                n_cmp++;
                if (done_a !== 1'b1 || m00_a !== 32'(sa00[s]) || m01_a !== 32'(sa01[s]) ||
                    m10_a !== 32'(sa10[s])) begin
                    n_bad++;
                    $display("FAIL stream8_strobe%0d: got done=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
                             s, done_a, m00_a, m01_a, m10_a, sa00[s], sa01[s], sa10[s]);
                end
            end
            if (c == 1004 || c == 1007) begin
                int s = (c == 1004) ? 0 : 1;
                n_cmp++;
                if (done_w !== 1'b1 || m00_w !== 32'(sw00[s]) || m01_w !== 32'(sw01[s]) ||
                    m10_w !== 32'(sw10[s])) begin
                    n_bad++;
                    $display("FAIL stream32_strobe%0d: got done=%b %0d/%0d/%0d want 1 %0d/%0d/%0d",
                             s, done_w, m00_w, m01_w, m10_w, sw00[s], sw01[s], sw10[s]);
                end
            end
            tick();
        end
        n_cmp++;
        if (strobes_a !== 2 || strobes_w !== 2) begin
            n_bad++;
            $display("FAIL stream_strobe_count: got %0d/%0d want 2/2", strobes_a, strobes_w);
        end
        n_cmp++;
        if (ovf_a !== 1'b0 || ovf_w !== 1'b0) begin
            n_bad++; $display("FAIL stream_ovf: got %b/%b want 0/0", ovf_a, ovf_w);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_valid_qualifier();
        test_saturation();
        test_clear_priority();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
